// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   NREQ     : number of requesters sharing the channel
//   SEL_W    : width of the mux select / requester index
//   rr_next  : rotate-priority winner search starting after last_ptr
`timescale 1ns/1ps
package rr_arb_pkg;
  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set bit at last_ptr+1, +2, ... +NREQ (mod NREQ). Scanning from the
  // far end and overwriting leaves the nearest candidate as the winner.
  // With req==0 the result is last_ptr and is meaningless to the caller.
  function automatic logic [SEL_W-1:0] rr_next(input logic [NREQ-1:0]  req,
                                               input logic [SEL_W-1:0] last_ptr);
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] cand;
    win = last_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last_ptr + SEL_W'(k);
      if (req[cand]) win = cand;
    end
    return win;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker.
//   req      in  NREQ   pending requests
//   last_ptr in  SEL_W  previous grant holder (lowest priority)
//   any      out 1      at least one request pending
//   idx      out SEL_W  winning requester index (valid when any=1)
`timescale 1ns/1ps
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  assign any = |req;
  assign idx = rr_next(req, last_ptr);
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter / sequencer for a shared 4:1 data mux.
// One requester holds the downstream valid/ready channel for up to
// MAX_BURST beats, then priority rotates past it.
//   clk, rst_n        clock, async active-low reset
//   req[3:0]          per-requester word pending
//   a, b, c, d        requester 0..3 data words
//   out_ready         downstream accept
//   out_valid         out_data valid (req of the grant holder)
//   out_data          selected requester word
//   sel               registered select (grant holder index)
//   gnt               registered one-hot grant, 0 when idle
//   ack               per-requester beat-consumed pulse
//   busy              in GRANT state
`timescale 1ns/1ps
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              busy
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0] last_ptr_q, last_ptr_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             xfer;

  rr_pick4 u_pick (
    .req      (req),
    .last_ptr (last_ptr_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // State and grant registers. last_ptr resets to NREQ-1 so requester 0
  // has first priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
      last_ptr_q <= SEL_W'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // Next-state / grant sequencing.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          sel_d      = pick_idx;
          gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        // Release on withdrawal or on the final beat of the burst; the
        // holder becomes lowest priority. sel is kept so out_data stays put.
        if (!req[sel_q] || (xfer && beat_cnt_q == LAST_BEAT)) begin
          state_d    = IDLE;
          gnt_d      = '0;
          beat_cnt_d = '0;
          last_ptr_d = sel_q;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs. out_valid is gated by GRANT so it can never assert with gnt==0.
  always_comb begin
    out_valid = (state_q == GRANT) && req[sel_q];
    busy      = (state_q == GRANT);
    case (sel_q)
      2'd0:    out_data = a;
      2'd1:    out_data = b;
      2'd2:    out_data = c;
      default: out_data = d;
    endcase
  end

  assign xfer = out_valid && out_ready;
  assign sel  = sel_q;
  assign gnt  = gnt_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_ack
    assign ack[i] = gnt_q[i] & xfer;
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a cycle table for single-grant,
// stall, withdrawal and reset scenarios on a MAX_BURST=4 instance, plus
// looped sequences for full rotation (MAX_BURST=4) and single-beat
// alternation (MAX_BURST=1).
`timescale 1ns/1ps
module tb_rr_mux_arbiter;
  localparam logic [3:0] WA = 4'hC, WB = 4'hA, WC = 4'h5, WD = 4'h3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] a, b, c, d;
  logic       out_ready;

  logic       v4, v1, bz4, bz1;
  logic [3:0] d4, d1, g4, g1, k4, k1;
  logic [1:0] s4, s1;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DATA_W(4), .MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .out_valid(v4), .out_data(d4), .sel(s4),
    .gnt(g4), .ack(k4), .busy(bz4));

  rr_mux_arbiter #(.DATA_W(4), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .out_valid(v1), .out_data(d1), .sel(s1),
    .gnt(g1), .ack(k1), .busy(bz1));

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] g;
    logic       v;
    logic [3:0] dat;
    logic [3:0] k;
    logic       bsy;
    logic [1:0] s;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic rs, input logic [3:0] rq, input logic rd,
                              input logic [3:0] g, input logic v, input logic [3:0] dat,
                              input logic [3:0] k, input logic bsy, input logic [1:0] s);
    vec_t e;
    e.rst_n = rs; e.req = rq; e.rdy = rd; e.g = g; e.v = v;
    e.dat = dat; e.k = k; e.bsy = bsy; e.s = s;
    return e;
  endfunction

  function automatic logic [3:0] word(input int i);
    case (i)
      0:       return WA;
      1:       return WB;
      2:       return WC;
      default: return WD;
    endcase
  endfunction

  task automatic cmp(input string nm, input int step, input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  task automatic chk(input string tag, input int step,
                     input logic [3:0] ag, input logic av, input logic [3:0] ad,
                     input logic [3:0] ak, input logic ab, input logic [1:0] as,
                     input logic [3:0] eg, input logic ev, input logic [3:0] ed,
                     input logic [3:0] ek, input logic eb, input logic [1:0] es);
    cmp({tag, ".gnt"},       step, ag,          eg);
    cmp({tag, ".out_valid"}, step, {3'b0, av},  {3'b0, ev});
    cmp({tag, ".out_data"},  step, ad,          ed);
    cmp({tag, ".ack"},       step, ak,          ek);
    cmp({tag, ".busy"},      step, {3'b0, ab},  {3'b0, eb});
    cmp({tag, ".sel"},       step, {2'b0, as},  {2'b0, es});
  endtask

  initial begin
    int w;
    a = WA; b = WB; c = WC; d = WD;
    rst_n = 1'b0; req = 4'b0; out_ready = 1'b1;

    // rst, req, rdy | gnt, valid, data, ack, busy, sel
    // single requester 0: 4-beat burst, idle, regrant, then withdraw
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, WA, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 1, 4'b0000, 0, WA, 4'b0000, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 4'b0001, 1, 4'b0001, 1, WA, 4'b0001, 1, 0));
    vecs.push_back(mk(1, 4'b0001, 1, 4'b0000, 0, WA, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0001, 0, WA, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, WA, 4'b0000, 0, 0));
    // requester 1 stalled 5 cycles, then 4 beats, idle, regrant
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, WA, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 0, WA, 4'b0000, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1, WB, 4'b0000, 1, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 4'b0010, 1, 4'b0010, 1, WB, 4'b0010, 1, 1));
    vecs.push_back(mk(1, 4'b0010, 1, 4'b0000, 0, WB, 4'b0000, 0, 1));
    vecs.push_back(mk(1, 4'b0010, 1, 4'b0010, 1, WB, 4'b0010, 1, 1));
    // requester 2 withdraws after 2 beats; 1001 pending -> 3 wins
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, WA, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 1, 4'b0000, 0, WA, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 1, 4'b0100, 1, WC, 4'b0100, 1, 2));
    vecs.push_back(mk(1, 4'b0100, 1, 4'b0100, 1, WC, 4'b0100, 1, 2));
    vecs.push_back(mk(1, 4'b1001, 1, 4'b0100, 0, WC, 4'b0000, 1, 2));
    vecs.push_back(mk(1, 4'b1001, 1, 4'b0000, 0, WC, 4'b0000, 0, 2));
    vecs.push_back(mk(1, 4'b1001, 1, 4'b1000, 1, WD, 4'b1000, 1, 3));
    // reset with grant 3 at beat_cnt=2, then 1111 -> 0 first
    vecs.push_back(mk(1, 4'b1001, 1, 4'b1000, 1, WD, 4'b1000, 1, 3));
    vecs.push_back(mk(0, 4'b1001, 1, 4'b0000, 0, WA, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, WA, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0001, 1, WA, 4'b0001, 1, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; req = vecs[i].req; out_ready = vecs[i].rdy;
      #1;
      chk("tbl", i, g4, v4, d4, k4, bz4, s4,
          vecs[i].g, vecs[i].v, vecs[i].dat, vecs[i].k, vecs[i].bsy, vecs[i].s);
    end

    // Full rotation with all four requesting, MAX_BURST=4
    @(negedge clk); rst_n = 1'b0; req = 4'b0000; out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1; req = 4'b1111;
    #1;
    chk("rot_idle0", 0, g4, v4, d4, k4, bz4, s4, 4'b0, 0, WA, 4'b0, 0, 0);
    for (int gi = 0; gi < 5; gi++) begin
      w = gi % 4;
      for (int bt = 0; bt < 4; bt++) begin
        @(negedge clk); #1;
        chk("rot_beat", gi * 10 + bt, g4, v4, d4, k4, bz4, s4,
            4'(1 << w), 1, word(w), 4'(1 << w), 1, 2'(w));
      end
      @(negedge clk); #1;
      chk("rot_idle", gi, g4, v4, d4, k4, bz4, s4, 4'b0, 0, word(w), 4'b0, 0, 2'(w));
    end

    // MAX_BURST=1: 0110 alternates 1,2 with one idle cycle between
    @(negedge clk); rst_n = 1'b0; req = 4'b0000;
    @(negedge clk); rst_n = 1'b1; req = 4'b0110;
    #1;
    chk("mb1_idle0", 0, g1, v1, d1, k1, bz1, s1, 4'b0, 0, WA, 4'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      w = (i % 2 == 0) ? 1 : 2;
      @(negedge clk); #1;
      chk("mb1_grant", i, g1, v1, d1, k1, bz1, s1,
          4'(1 << w), 1, word(w), 4'(1 << w), 1, 2'(w));
      @(negedge clk); #1;
      chk("mb1_idle", i, g1, v1, d1, k1, bz1, s1, 4'b0, 0, word(w), 4'b0, 0, 2'(w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
